// File: rtl/preprocess_host_seq.sv
// DP1/INTT job sequencer: stream in -> DP1 write -> INTT kick/wait -> DP1 read -> stream out; PREPROC_HOST_TIMEOUT_EN adds a WAIT watchdog.
// Latency: writes are combinational on the input beat; read data reaches m_data two cycles after rdaddr issue.
// Backpressure: s_ready only in LOAD; m_ready stalls the 2-entry output FIFO, which throttles DP1 reads.
module preprocess_host_seq #(
  parameter int DATA_WIDTH = 39,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_start,
  input  logic [ADDR_WIDTH-1:0]   cfg_len,
  input  logic [11:0]             cfg_index,
  output logic                    busy,
  output logic                    done,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    io_i_dp1_wren,
  output logic [ADDR_WIDTH-1:0]   io_i_dp1_wraddr,
  output logic [2*DATA_WIDTH-1:0] io_i_dp1_wrdata,
  output logic [ADDR_WIDTH-1:0]   io_i_dp1_rdaddr,
  input  logic [2*DATA_WIDTH-1:0] io_o_dp1_rddata,
  output logic                    io_i_intt_start,
  input  logic                    io_o_intt_done,
  output logic                    io_i_pre_switch,
  output logic                    io_i_mux_done,
  output logic [11:0]             io_i_coeff_index
`ifdef PREPROC_HOST_TIMEOUT_EN
  ,
  output logic                    err_timeout
`endif
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_DRAIN, S_FIN} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         len_q, wcnt, rcnt, ocnt;
  logic                  wait_armed;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  fifo_rp, fifo_wp;
  logic [1:0]            fifo_cnt;
  logic [ADDR_WIDTH-1:0] rdaddr_q;
  logic                  wr_beat, rd_issue, push, pop, last_pop, intt_seen, timeout_hit;
  logic                  unused_rd_hi;

  assign unused_rd_hi = ^io_o_dp1_rddata[2*DATA_WIDTH-1:DATA_WIDTH];

`ifdef PREPROC_HOST_TIMEOUT_EN
  logic [15:0] wd_cnt;
  // wd_cnt is 0 on the first WAIT cycle, so FFFE marks the 65535th one
  assign timeout_hit = (state == S_WAIT) && !intt_seen && (wd_cnt == 16'hFFFE);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    wr_beat   = (state == S_LOAD) && s_valid;
    pop       = (fifo_cnt != 2'd0) && m_ready;
    push      = inflight;
    // a same-cycle pop frees a slot, keeping the drain at one beat per cycle
    rd_issue  = (state == S_DRAIN) && (rcnt <= len_q) &&
                (({1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
    last_pop  = pop && (ocnt == len_q);
    intt_seen = (state == S_WAIT) && wait_armed && io_o_intt_done;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_start) state_nxt = S_LOAD;
      S_LOAD:  if (wr_beat && (wcnt == len_q)) state_nxt = S_KICK;
      S_KICK:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (intt_seen)        state_nxt = S_DRAIN;
        else if (timeout_hit) state_nxt = S_FIN;
      end
      S_DRAIN: if (last_pop) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state != S_IDLE);
    s_ready         = (state == S_LOAD);
    io_i_dp1_wren   = wr_beat;
    io_i_dp1_wraddr = wcnt[ADDR_WIDTH-1:0];
    io_i_dp1_wrdata = {{DATA_WIDTH{1'b0}}, s_data};
    io_i_dp1_rdaddr = rd_issue ? rcnt[ADDR_WIDTH-1:0] : rdaddr_q;
    io_i_intt_start = (state == S_KICK);
    io_i_pre_switch = (state == S_KICK);
    done            = (state == S_FIN);
    io_i_mux_done   = (state == S_FIN);
    m_valid         = (fifo_cnt != 2'd0);
    m_data          = fifo_mem[fifo_rp];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      len_q            <= '0;
      wcnt             <= '0;
      rcnt             <= '0;
      ocnt             <= '0;
      wait_armed       <= 1'b0;
      inflight         <= 1'b0;
      fifo_mem[0]      <= '0;
      fifo_mem[1]      <= '0;
      fifo_rp          <= 1'b0;
      fifo_wp          <= 1'b0;
      fifo_cnt         <= 2'd0;
      rdaddr_q         <= '0;
      io_i_coeff_index <= 12'h000;
    end else begin
      state      <= state_nxt;
      rdaddr_q   <= io_i_dp1_rdaddr;
      inflight   <= rd_issue;
      // low on the first WAIT cycle so a done level left over from before KICK is ignored
      wait_armed <= (state == S_WAIT);
      if ((state == S_IDLE) && cmd_start) begin
        len_q            <= {1'b0, cfg_len};
        io_i_coeff_index <= cfg_index;
        wcnt             <= '0;
        rcnt             <= '0;
        ocnt             <= '0;
      end
      if (wr_beat)  wcnt <= wcnt + 1'b1;
      if (rd_issue) rcnt <= rcnt + 1'b1;
      if (push) begin
        fifo_mem[fifo_wp] <= io_o_dp1_rddata[DATA_WIDTH-1:0];
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) begin
        fifo_rp <= ~fifo_rp;
        ocnt    <= ocnt + 1'b1;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef PREPROC_HOST_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt      <= 16'h0000;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT) ? wd_cnt + 16'h0001 : 16'h0000;
      if ((state == S_IDLE) && cmd_start) err_timeout <= 1'b0;
      else if (timeout_hit)               err_timeout <= 1'b1;
    end
  end
`endif

endmodule
